// File: rtl/demon_pkg.sv
`default_nettype none
// ============================================================================
//  demon_pkg
//  Shared types and constants for the DeMoN cartridge trigger controller.
//  Revision: 1.0
// ============================================================================
package demon_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        NMI_REQ   = 3'd1,
        VEC_FETCH = 3'd2,
        RUNNING   = 3'd3,
        EXITING   = 3'd4
    } state_t;

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_READ  = 2'b01;
    localparam logic [1:0] MODE_WRITE = 2'b10;
    localparam logic [1:0] MODE_ANY   = 2'b11;

    localparam logic [1:0] SEL_MATCH  = 2'b00;
    localparam logic [1:0] SEL_MASK   = 2'b01;
    localparam logic [1:0] SEL_MODE   = 2'b10;
    localparam logic [1:0] SEL_EXIT   = 2'b11;

    localparam logic [3:0] CAUSE_BUTTON = 4'd0;
    localparam logic [3:0] CAUSE_RESET  = 4'd14;
    localparam logic [3:0] CAUSE_NONE   = 4'd15;

    localparam logic [2:0] FC_IACK     = 3'b111;
    localparam logic [2:0] FC_SUP_DATA = 3'b101;

endpackage
`default_nettype wire

// File: rtl/demon_bp_channel.sv
`default_nettype none
// ============================================================================
//  demon_bp_channel
//  One programmable address/mask/direction breakpoint comparator.
//  Revision: 1.0
// ============================================================================
module demon_bp_channel
    import demon_pkg::*;
#(
    parameter int ADDR_W = 23
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [1:0]        i_sel,
    input  logic [ADDR_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_r_w,
    output logic              o_hit
);

    logic [ADDR_W-1:0] r_match;
    logic [ADDR_W-1:0] r_mask;
    logic [1:0]        r_mode;
    logic              w_dir_ok;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_match <= '0;
            r_mask  <= '1;
            r_mode  <= MODE_OFF;
        end else if (i_we) begin
            case (i_sel)
                SEL_MATCH: r_match <= i_wdata;
                SEL_MASK:  r_mask  <= i_wdata;
                SEL_MODE:  r_mode  <= i_wdata[1:0];
                default:   ;
            endcase
        end
    end

    always_comb begin
        w_dir_ok = 1'b0;
        case (r_mode)
            MODE_READ:  w_dir_ok = i_r_w;
            MODE_WRITE: w_dir_ok = !i_r_w;
            MODE_ANY:   w_dir_ok = 1'b1;
            default:    w_dir_ok = 1'b0;
        endcase
    end

    assign o_hit = w_dir_ok && (((i_addr ^ r_match) & r_mask) == '0);

endmodule
`default_nettype wire

// File: rtl/demon_trigger_ctrl.sv
`default_nettype none
// ============================================================================
//  demon_trigger_ctrl
//  Programmable freeze-trigger decode and NMI entry sequencer for DeMoN.
//  Revision: 1.0
// ============================================================================
module demon_trigger_ctrl
    import demon_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int ADDR_W       = 23,
    parameter int DEBOUNCE_CYC = 16,
    parameter int IACK_TIMEOUT = 1024,
    parameter int RESET_TRIG   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              as_n,
    input  logic              lds_n,
    input  logic              uds_n,
    input  logic              r_w,
    input  logic [2:0]        fc,
    input  logic              sw1_n,
    input  logic              jp2,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_ch,
    input  logic [1:0]        cfg_sel,
    input  logic [ADDR_W-1:0] cfg_wdata,
    output logic              ipl_n,
    output logic              ovr_req,
    output logic              running,
    output logic [3:0]        cause,
    output logic              timeout
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYC + 1);
    localparam int TMO_W = $clog2(IACK_TIMEOUT + 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(IACK_TIMEOUT - 1);

    logic              r_as_n_q;
    logic              w_start;
    logic              w_as_rise;
    logic              w_strb;
    logic [NUM_CH-1:0] w_ch_hit;
    logic [NUM_CH-1:0] w_ch_evt;
    logic [NUM_CH-1:0] r_pend;

    assign w_start   = !as_n && r_as_n_q;
    assign w_as_rise = as_n && !r_as_n_q;
    assign w_strb    = !lds_n || !uds_n;

    // A hit whose strobes are still high at the start gets one more cycle.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            demon_bp_channel #(.ADDR_W(ADDR_W)) u_ch (
                .clk     (clk),
                .rst     (rst),
                .i_we    (cfg_we && (cfg_sel != SEL_EXIT) && (cfg_ch == 3'(gi))),
                .i_sel   (cfg_sel),
                .i_wdata (cfg_wdata),
                .i_addr  (addr),
                .i_r_w   (r_w),
                .o_hit   (w_ch_hit[gi])
            );
            assign w_ch_evt[gi] = w_strb && ((w_start && w_ch_hit[gi]) || r_pend[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_as_n_q <= 1'b1;
            r_pend   <= '0;
        end else begin
            r_as_n_q <= as_n;
            r_pend   <= w_start ? (w_ch_hit & {NUM_CH{!w_strb}}) : '0;
        end
    end

    // Counter tracks lows while armed and highs while waiting to re-arm.
    logic [DB_W-1:0] r_db_cnt;
    logic            r_btn_armed;
    logic            w_btn_evt;
    assign w_btn_evt = r_btn_armed && !sw1_n && (r_db_cnt == DB_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_db_cnt    <= '0;
            r_btn_armed <= 1'b1;
        end else if (r_btn_armed == sw1_n) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == DB_LAST) begin
            r_db_cnt    <= '0;
            r_btn_armed <= !r_btn_armed;
        end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    logic r_rst_arm;
    logic w_rst_evt;
    assign w_rst_evt = r_rst_arm && w_start && (addr == ADDR_W'(4)) && r_w;

    always_ff @(posedge clk) begin
        if (!rst)
            r_rst_arm <= (RESET_TRIG != 0);
        else if (w_rst_evt || (w_start && (addr >= ADDR_W'(6))))
            r_rst_arm <= 1'b0;
    end

    logic       w_any_trig;
    logic [3:0] w_trig_cause;

    always_comb begin
        w_any_trig   = w_btn_evt || (|w_ch_evt) || w_rst_evt;
        w_trig_cause = CAUSE_NONE;
        if (w_rst_evt)
            w_trig_cause = CAUSE_RESET;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_ch_evt[i])
                w_trig_cause = 4'(i + 1);
        end
        if (w_btn_evt)
            w_trig_cause = CAUSE_BUTTON;
    end

    state_t           r_state, w_state_nxt;
    logic             r_ipl_n, w_ipl_n_nxt;
    logic             r_ovr, w_ovr_nxt;
    logic             r_run, w_run_nxt;
    logic [3:0]       r_cause, w_cause_nxt;
    logic             r_tmo, w_tmo_nxt;
    logic [TMO_W-1:0] r_iack_cnt, w_iack_cnt_nxt;
    logic             r_rd_cnt, w_rd_cnt_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_ipl_n    <= 1'b1;
            r_ovr      <= 1'b0;
            r_run      <= 1'b0;
            r_cause    <= CAUSE_NONE;
            r_tmo      <= 1'b0;
            r_iack_cnt <= '0;
            r_rd_cnt   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ipl_n    <= w_ipl_n_nxt;
            r_ovr      <= w_ovr_nxt;
            r_run      <= w_run_nxt;
            r_cause    <= w_cause_nxt;
            r_tmo      <= w_tmo_nxt;
            r_iack_cnt <= w_iack_cnt_nxt;
            r_rd_cnt   <= w_rd_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ipl_n_nxt    = r_ipl_n;
        w_ovr_nxt      = r_ovr;
        w_run_nxt      = r_run;
        w_cause_nxt    = r_cause;
        w_tmo_nxt      = r_tmo;
        w_iack_cnt_nxt = r_iack_cnt;
        w_rd_cnt_nxt   = r_rd_cnt;
        case (r_state)
            IDLE: begin
                if (w_any_trig && !jp2) begin
                    w_state_nxt    = NMI_REQ;
                    w_ipl_n_nxt    = 1'b0;
                    w_cause_nxt    = w_trig_cause;
                    w_tmo_nxt      = 1'b0;
                    w_iack_cnt_nxt = '0;
                end
            end
            NMI_REQ: begin
                if (w_start && (fc == FC_IACK) && (addr[2:0] == 3'b111)) begin
                    w_state_nxt  = VEC_FETCH;
                    w_ipl_n_nxt  = 1'b1;
                    w_ovr_nxt    = 1'b1;
                    w_rd_cnt_nxt = 1'b0;
                end else if (r_iack_cnt == TMO_LAST) begin
                    w_state_nxt = IDLE;
                    w_ipl_n_nxt = 1'b1;
                    w_tmo_nxt   = 1'b1;
                end else begin
                    w_iack_cnt_nxt = r_iack_cnt + 1'b1;
                end
            end
            VEC_FETCH: begin
                if (w_as_rise && (fc == FC_SUP_DATA) && r_w) begin
                    if (r_rd_cnt) begin
                        w_state_nxt = RUNNING;
                        w_ovr_nxt   = 1'b0;
                        w_run_nxt   = 1'b1;
                    end else begin
                        w_rd_cnt_nxt = 1'b1;
                    end
                end
            end
            RUNNING: begin
                if (cfg_we && (cfg_sel == SEL_EXIT))
                    w_state_nxt = EXITING;
            end
            EXITING: begin
                // Hold running until the RTE fetch cycle has finished.
                if (w_as_rise) begin
                    w_state_nxt = IDLE;
                    w_run_nxt   = 1'b0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign ipl_n   = r_ipl_n;
    assign ovr_req = r_ovr;
    assign running = r_run;
    assign cause   = r_cause;
    assign timeout = r_tmo;

endmodule
`default_nettype wire

// File: tb/tb_demon_trigger_ctrl.sv
`default_nettype none
// ============================================================================
//  tb_demon_trigger_ctrl
//  Self-checking bench with a behavioural trigger model and random bus cycles.
//  Revision: 1.0
// ============================================================================
module tb_demon_trigger_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [22:0] addr = '0;
    logic        as_n = 1'b1, lds_n = 1'b1, uds_n = 1'b1, r_w = 1'b1;
    logic [2:0]  fc = 3'd0;
    logic        sw1_n = 1'b1, jp2 = 1'b0, cfg_we = 1'b0;
    logic [2:0]  cfg_ch = 3'd0;
    logic [1:0]  cfg_sel = 2'd0;
    logic [22:0] cfg_wdata = '0;
    logic        ipl_n, ovr_req, running, timeout;
    logic [3:0]  cause;

    int errors = 0;
    int checks = 0;

    // Reference model state: programmed channels and reset-vector arm.
    logic [22:0] m_match [4];
    logic [22:0] m_mask  [4];
    logic [1:0]  m_mode  [4];
    bit          m_rst_arm;

    demon_trigger_ctrl dut (
        .clk(clk), .rst(rst), .addr(addr), .as_n(as_n), .lds_n(lds_n), .uds_n(uds_n),
        .r_w(r_w), .fc(fc), .sw1_n(sw1_n), .jp2(jp2), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata), .ipl_n(ipl_n), .ovr_req(ovr_req),
        .running(running), .cause(cause), .timeout(timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit m_hit(input int ch, input logic [22:0] a, input bit rw);
        if (m_mode[ch] == 2'd0) return 1'b0;
        if (((a ^ m_match[ch]) & m_mask[ch]) != 23'd0) return 1'b0;
        case (m_mode[ch])
            2'd1:    return rw;
            2'd2:    return !rw;
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_match[i] = '0; m_mask[i] = '1; m_mode[i] = 2'd0;
        end
        m_rst_arm = 1'b1;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic bus_start(input logic [22:0] a, input logic rw, input logic [2:0] f, input bit strb);
        addr = a; r_w = rw; fc = f; as_n = 1'b0; lds_n = !strb; uds_n = !strb;
        if (a >= 23'd6 || (a == 23'd4 && rw)) m_rst_arm = 1'b0;
        tick();
    endtask

    task automatic bus_end();
        as_n = 1'b1; lds_n = 1'b1; uds_n = 1'b1;
        tick();
    endtask

    task automatic prog(input int ch, input logic [1:0] sel, input logic [22:0] d);
        cfg_we = 1'b1; cfg_ch = 3'(ch); cfg_sel = sel; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
        if (sel != 2'b11 && ch < 4) begin
            case (sel)
                2'b00:   m_match[ch] = d;
                2'b01:   m_mask[ch]  = d;
                default: m_mode[ch]  = d[1:0];
            endcase
        end
    endtask

    // IACK, two vector reads, exit command, then the RTE cycle.
    task automatic finish_seq();
        bus_start(23'h7FFFFF, 1'b1, 3'b111, 1'b1); bus_end();
        bus_start(23'h000100, 1'b1, 3'b101, 1'b1); bus_end();
        bus_start(23'h000100, 1'b1, 3'b101, 1'b1); bus_end();
        prog(0, 2'b11, '0);
        bus_start(23'h000100, 1'b1, 3'b101, 1'b1); bus_end();
    endtask

    task automatic test_reset();
        rst = 1'b0; tick(); tick();
        model_reset();
        checks++; if (ipl_n !== 1'b1)   begin errors++; $display("FAIL reset_ipl_n: got %b want 1", ipl_n); end
        checks++; if (ovr_req !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", ovr_req); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", running); end
        checks++; if (cause !== 4'd15)  begin errors++; $display("FAIL reset_cause: got %0d want 15", cause); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        rst = 1'b1; tick();
    endtask

    task automatic test_reset_vector();
        bus_start(23'd4, 1'b1, 3'b110, 1'b1);
        checks++; if (ipl_n !== 1'b0) begin errors++; $display("FAIL rvec_ipl_n: got %b want 0", ipl_n); end
        checks++; if (cause !== 4'd14) begin errors++; $display("FAIL rvec_cause: got %0d want 14", cause); end
        bus_end();
        finish_seq();
        bus_start(23'd4, 1'b1, 3'b110, 1'b1);
        checks++; if (ipl_n !== 1'b1) begin errors++; $display("FAIL rvec_rearm: got ipl_n %b want 1", ipl_n); end
        bus_end();
    endtask

    task automatic test_ch0_sequence();
        prog(0, 2'b00, 23'h5FF000); prog(0, 2'b01, 23'h7FFFFF); prog(0, 2'b10, 23'd1);
        bus_start(23'h5FF000, 1'b1, 3'b101, 1'b1);
        checks++; if (ipl_n !== 1'b0) begin errors++; $display("FAIL ch0_ipl_n: got %b want 0", ipl_n); end
        checks++; if (cause !== 4'd1) begin errors++; $display("FAIL ch0_cause: got %0d want 1", cause); end
        bus_end();
        checks++; if (ovr_req !== 1'b0) begin errors++; $display("FAIL ch0_ovr_pre: got %b want 0", ovr_req); end
        bus_start(23'h7FFFFF, 1'b1, 3'b111, 1'b1);
        checks++; if (ovr_req !== 1'b1 || ipl_n !== 1'b1) begin errors++; $display("FAIL ch0_iack: got ovr %b ipl_n %b want 1 1", ovr_req, ipl_n); end
        bus_end();
        bus_start(23'h000100, 1'b1, 3'b101, 1'b1); bus_end();
        checks++; if (ovr_req !== 1'b1 || running !== 1'b0) begin errors++; $display("FAIL ch0_read1: got ovr %b run %b want 1 0", ovr_req, running); end
        bus_start(23'h000101, 1'b1, 3'b101, 1'b1);
        checks++; if (ovr_req !== 1'b1) begin errors++; $display("FAIL ch0_read2_ovr: got %b want 1", ovr_req); end
        bus_end();
        checks++; if (ovr_req !== 1'b0 || running !== 1'b1) begin errors++; $display("FAIL ch0_running: got ovr %b run %b want 0 1", ovr_req, running); end
        prog(0, 2'b11, '0);
        bus_start(23'h000100, 1'b1, 3'b101, 1'b1);
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL ch0_exiting: got run %b want 1", running); end
        bus_end();
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL ch0_exit_done: got run %b want 0", running); end
    endtask

    task automatic test_running_ignore();
        bus_start(23'h5FF000, 1'b1, 3'b101, 1'b1); bus_end();
        bus_start(23'h7FFFFF, 1'b1, 3'b111, 1'b1); bus_end();
        bus_start(23'h000100, 1'b1, 3'b101, 1'b1); bus_end();
        bus_start(23'h000100, 1'b1, 3'b101, 1'b1); bus_end();
        bus_start(23'h5FF000, 1'b1, 3'b101, 1'b1);
        checks++; if (ipl_n !== 1'b1 || running !== 1'b1) begin errors++; $display("FAIL run_ignore: got ipl_n %b run %b want 1 1", ipl_n, running); end
        bus_end();
        prog(0, 2'b11, '0);
        bus_start(23'h000100, 1'b1, 3'b101, 1'b1); bus_end();
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL run_exit: got %b want 0", running); end
    endtask

    task automatic test_button();
        sw1_n = 1'b0; repeat (15) tick();
        checks++; if (ipl_n !== 1'b1) begin errors++; $display("FAIL btn_15: got ipl_n %b want 1", ipl_n); end
        sw1_n = 1'b1; tick();
        sw1_n = 1'b0; repeat (16) tick();
        checks++; if (ipl_n !== 1'b0 || cause !== 4'd0) begin errors++; $display("FAIL btn_16: got ipl_n %b cause %0d want 0 0", ipl_n, cause); end
        finish_seq();
        repeat (20) tick();
        checks++; if (ipl_n !== 1'b1) begin errors++; $display("FAIL btn_once: got ipl_n %b want 1", ipl_n); end
        sw1_n = 1'b1; repeat (20) tick();
    endtask

    task automatic test_back_to_back();
        prog(1, 2'b00, 23'h5FE880); prog(1, 2'b10, 23'd2);
        prog(3, 2'b00, 23'h5FE880); prog(3, 2'b10, 23'd3);
        sw1_n = 1'b0; repeat (15) tick();
        bus_start(23'h5FE880, 1'b0, 3'b001, 1'b1);
        checks++; if (ipl_n !== 1'b0 || cause !== 4'd0) begin errors++; $display("FAIL b2b_button: got ipl_n %b cause %0d want 0 0", ipl_n, cause); end
        bus_end();
        finish_seq();
        sw1_n = 1'b1; repeat (20) tick();
        bus_start(23'h5FE880, 1'b0, 3'b001, 1'b1);
        checks++; if (ipl_n !== 1'b0 || cause !== 4'd2) begin errors++; $display("FAIL b2b_chan: got ipl_n %b cause %0d want 0 2", ipl_n, cause); end
        bus_end();
        finish_seq();
    endtask

    task automatic test_timeout();
        int n;
        bus_start(23'h5FF000, 1'b1, 3'b101, 1'b1); bus_end();
        repeat (1018) tick();
        checks++; if (ipl_n !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL tmo_early: got ipl_n %b tmo %b want 0 0", ipl_n, timeout); end
        n = 0;
        while (ipl_n !== 1'b1 && n < 12) begin tick(); n++; end
        checks++; if (ipl_n !== 1'b1 || timeout !== 1'b1) begin errors++; $display("FAIL tmo_fire: got ipl_n %b tmo %b want 1 1", ipl_n, timeout); end
        bus_start(23'h5FF000, 1'b1, 3'b101, 1'b1);
        checks++; if (ipl_n !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL tmo_clear: got ipl_n %b tmo %b want 0 0", ipl_n, timeout); end
        bus_end();
        finish_seq();
    endtask

    task automatic test_random();
        logic [22:0] a;
        bit          rw, jp, exp_rst, trig, found;
        int          k, dly;
        logic [3:0]  ecause;
        prog(4, 2'b10, 23'd3);
        for (int it = 0; it < 40; it++) begin
            if (it % 4 == 0) begin
                k = $urandom_range(0, 3);
                prog(k, 2'b00, 23'($urandom));
                prog(k, 2'b01, 23'($urandom) | 23'h7E0000);
                prog(k, 2'b10, 23'($urandom_range(0, 3)));
            end
            k = $urandom_range(0, 3);
            a = ($urandom_range(0, 2) != 0) ? (m_match[k] ^ (23'($urandom) & ~m_mask[k])) : 23'($urandom);
            rw = 1'($urandom_range(0, 1));
            dly = $urandom_range(0, 2);
            jp = ($urandom_range(0, 5) == 0);
            exp_rst = m_rst_arm && a == 23'd4 && rw;
            ecause = 4'd14; found = 1'b0;
            if (dly < 2) begin
                for (int i = 0; i < 4; i++) begin
                    if (!found && m_hit(i, a, rw)) begin ecause = 4'(i + 1); found = 1'b1; end
                end
            end
            if (exp_rst && dly > 0) ecause = 4'd14;
            trig = !jp && (found || exp_rst);
            jp2 = jp;
            bus_start(a, rw, 3'b001, dly == 0);
            if (dly > 0) begin
                checks++; if (ipl_n !== !(!jp && exp_rst)) begin errors++; $display("FAIL rnd_pend it=%0d: got ipl_n %b want %b", it, ipl_n, !(!jp && exp_rst)); end
                if (dly == 2) tick();
                lds_n = 1'b0; tick();
            end
            checks++; if (ipl_n !== !trig) begin errors++; $display("FAIL rnd_trig it=%0d a=%h rw=%b dly=%0d: got ipl_n %b want %b", it, a, rw, dly, ipl_n, !trig); end
            if (trig) begin
                checks++; if (cause !== ecause) begin errors++; $display("FAIL rnd_cause it=%0d: got %0d want %0d", it, cause, ecause); end
            end
            bus_end();
            jp2 = 1'b0;
            if (trig) finish_seq();
        end
    endtask

    task automatic test_reset_mid();
        prog(0, 2'b00, 23'h5FF000); prog(0, 2'b01, 23'h7FFFFF); prog(0, 2'b10, 23'd1);
        bus_start(23'h5FF000, 1'b1, 3'b101, 1'b1); bus_end();
        bus_start(23'h7FFFFF, 1'b1, 3'b111, 1'b1); bus_end();
        checks++; if (ovr_req !== 1'b1) begin errors++; $display("FAIL mid_vec: got ovr %b want 1", ovr_req); end
        rst = 1'b0; tick();
        model_reset();
        checks++; if (ipl_n !== 1'b1 || ovr_req !== 1'b0 || running !== 1'b0 || cause !== 4'd15 || timeout !== 1'b0)
            begin errors++; $display("FAIL mid_reset: got ipl_n %b ovr %b run %b cause %0d tmo %b want 1 0 0 15 0", ipl_n, ovr_req, running, cause, timeout); end
        rst = 1'b1; tick();
        bus_start(23'h5FF000, 1'b1, 3'b101, 1'b1);
        checks++; if (ipl_n !== 1'b1) begin errors++; $display("FAIL mid_modes_off: got ipl_n %b want 1", ipl_n); end
        bus_end();
    endtask

    initial begin
        tick();
        test_reset();
        test_reset_vector();
        test_ch0_sequence();
        test_running_ignore();
        test_button();
        test_back_to_back();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
